pc_sequencer: RTL

- Program-counter sequencer that consumes the single-bit branch decision produced by the condition evaluator.
- On each accepted instruction it either advances PC by one instruction or loads the branch target.
- After a taken branch it issues a one-cycle flush so the fetch stage squashes the wrong-path instruction.
- Sits between decode/condition evaluation and instruction fetch in the CPU datapath.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_sequencer_return_stack.sv | 40 ++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

    localparam int unsigned PC_W_DEF        = 8;
    localparam int unsigned INSTR_BYTES_DEF = 4;
    localparam int unsigned STACK_DEPTH_DEF = 8;
    localparam int unsigned SP_W            = $clog2(STACK_DEPTH_DEF) + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    // Clears the sub-instruction offset bits within a pc_w-bit address.
    function automatic logic [31:0] align_mask(input int unsigned pc_w,
                                               input int unsigned instr_bytes);
        logic [31:0] width_mask;
        width_mask = (pc_w >= 32) ? '1 : ((32'd1 << pc_w) - 32'd1);
        return width_mask & ~(32'(instr_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses; pushes when full and pops when empty are ignored.
module return_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q;

    assign full_o  = (sp_q == PTR_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign dout_o  = mem_q[IDX_W'(sp_q - PTR_W'(1))];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sp_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[IDX_W'(sp_q)] <= din_i;
            sp_q                <= sp_q + PTR_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - PTR_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: increment / taken-branch load with a one-cycle flush, and halt.
// Optional return stack with call/ret when PC_SEQUENCER_CALL_STACK_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            instr_valid_i,
    input  logic            is_branch_i,
    input  logic            take_i,
    input  logic [PC_W-1:0] target_i,
    input  logic            stall_i,
    input  logic            halt_req_i,
    output logic [PC_W-1:0] pc_o,
    output logic            flush_o,
    output logic            halted_o
`ifdef PC_SEQUENCER_CALL_STACK_EN
    ,
    input  logic            is_call_i,
    input  logic            is_ret_i,
    output logic            stack_err_o
`endif
);

    localparam logic [PC_W-1:0] ALIGN = PC_W'(align_mask(PC_W, INSTR_BYTES));
    localparam logic [PC_W-1:0] STEP  = PC_W'(INSTR_BYTES);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            halted_q, halted_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] tgt_aligned;

    assign pc_inc      = pc_q + STEP;
    assign tgt_aligned = target_i & ALIGN;

`ifdef PC_SEQUENCER_CALL_STACK_EN
    logic            rs_push, rs_pop, rs_full, rs_empty;
    logic [PC_W-1:0] rs_top;
    logic            err_q, err_d;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_return_stack (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (rs_push),
        .pop_i   (rs_pop),
        .din_i   (pc_inc),
        .dout_o  (rs_top),
        .full_o  (rs_full),
        .empty_o (rs_empty)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign stack_err_o = err_q;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_SEQUENCER_CALL_STACK_EN
        rs_push = 1'b0;
        rs_pop  = 1'b0;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_RUN: begin
                // Halt outranks stall; a stalled instruction is otherwise not consumed.
                if (instr_valid_i && halt_req_i) begin
                    state_d = ST_HALT;
                end else if (instr_valid_i && !stall_i) begin
`ifdef PC_SEQUENCER_CALL_STACK_EN
                    if (is_call_i) begin
                        rs_push = 1'b1;
                        if (rs_full) err_d = 1'b1;
                        pc_d    = tgt_aligned;
                        state_d = ST_FLUSH;
                    end else if (is_ret_i) begin
                        if (rs_empty) begin
                            err_d = 1'b1;
                            pc_d  = pc_inc;
                        end else begin
                            rs_pop  = 1'b1;
                            pc_d    = rs_top;
                            state_d = ST_FLUSH;
                        end
                    end else
`endif
                    if (is_branch_i && take_i) begin
                        pc_d    = tgt_aligned;
                        state_d = ST_FLUSH;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
        flush_d  = (state_d == ST_FLUSH);
        halted_d = (state_d == ST_HALT);
    end

    assign pc_o     = pc_q;
    assign flush_o  = flush_q;
    assign halted_o = halted_q;

endmodule
